// File: rtl/slot_allocator.sv
// Lowest-index-first slot ID allocator with a registered one-entry offer stage.
// Includes the trailing/leading zero counter used to pick the next free slot.

module lzc #(
    parameter int unsigned WIDTH = 2,
    parameter bit MODE = 1'b0,
    localparam int unsigned CntWidth = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    // Last match wins: MODE 0 scans downwards so the lowest set bit sticks.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (MODE == 1'b0) begin
                if (in_i[WIDTH-1-i]) begin
                    empty_o = 1'b0;
                    cnt_o   = CntWidth'(WIDTH - 1 - i);
                end
            end else begin
                if (in_i[i]) begin
                    empty_o = 1'b0;
                    cnt_o   = CntWidth'(WIDTH - 1 - i);
                end
            end
        end
    end

endmodule

module slot_allocator #(
    parameter int unsigned NUM_SLOTS = 8,
    localparam int unsigned IdWidth  = $clog2(NUM_SLOTS),
    localparam int unsigned CntWidth = $clog2(NUM_SLOTS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                alloc_valid_o,
    input  logic                alloc_ready_i,
    output logic [IdWidth-1:0]  alloc_id_o,
    input  logic                free_valid_i,
    input  logic [IdWidth-1:0]  free_id_i,
    output logic [CntWidth-1:0] used_cnt_o,
    output logic                err_o
);

    if (NUM_SLOTS < 2) begin : g_bad_cfg
        $fatal(1, "slot_allocator: NUM_SLOTS must be at least 2");
    end

    localparam int unsigned ExtWidth = 2 ** IdWidth;
    localparam logic [NUM_SLOTS-1:0] OneHot = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic                 off_valid_q;
    logic [IdWidth-1:0]   off_id_q;
    logic [CntWidth-1:0]  used_q, used_d;
    logic                 err_q;

    logic [IdWidth-1:0]   lowest_free;
    logic                 none_free;
    logic [ExtWidth-1:0]  busy_ext;
    logic                 handshake, load, drain;
    logic                 free_legal, free_illegal;
    logic [NUM_SLOTS-1:0] reserve_mask, free_mask;

    lzc #(
        .WIDTH (NUM_SLOTS),
        .MODE  (1'b0)
    ) u_lzc (
        .in_i    (~busy_q),
        .cnt_o   (lowest_free),
        .empty_o (none_free)
    );

    // Zero-padded so out-of-range free IDs index a defined bit.
    always_comb begin
        busy_ext = '0;
        busy_ext[NUM_SLOTS-1:0] = busy_q;
    end

    assign handshake = off_valid_q & alloc_ready_i;
    assign load      = (~off_valid_q | handshake) & ~none_free;
    assign drain     = handshake & none_free;

    assign free_legal = free_valid_i
                      & (32'(free_id_i) < NUM_SLOTS)
                      & busy_ext[free_id_i]
                      & ~(off_valid_q & (free_id_i == off_id_q));
    assign free_illegal = free_valid_i & ~free_legal;

    assign reserve_mask = load ? (OneHot << lowest_free) : '0;
    assign free_mask    = free_legal ? (OneHot << free_id_i) : '0;
    assign busy_d       = (busy_q | reserve_mask) & ~free_mask;

    always_comb begin
        used_d = used_q;
        if (handshake & ~free_legal) begin
            used_d = used_q + CntWidth'(1);
        end else if (~handshake & free_legal) begin
            used_d = used_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            off_valid_q <= 1'b0;
            off_id_q    <= '0;
            used_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q <= busy_d;
            used_q <= used_d;
            err_q  <= free_illegal;
            if (load) begin
                off_valid_q <= 1'b1;
                off_id_q    <= lowest_free;
            end else if (drain) begin
                off_valid_q <= 1'b0;
            end
        end
    end

    assign alloc_valid_o = off_valid_q;
    assign alloc_id_o    = off_id_q;
    assign used_cnt_o    = used_q;
    assign err_o         = err_q;

endmodule
